// File: rtl/store_operation_if.sv
// Bundle of the store executor's control, register-file read and memory write signals.
// The slave modport is the executor's view; master is the surrounding pipeline/memory.
interface store_operation_if;
   logic        start;
   logic [31:0] instruction;
   logic        busy;
   logic        done;
   logic [1:0]  err_code;
   logic [4:0]  rf_raddr1;
   logic [4:0]  rf_raddr2;
   logic [31:0] rf_rdata1;
   logic [31:0] rf_rdata2;
   logic        mem_write;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_be;
   logic        mem_ready;

   modport slave (
      input  start, instruction, rf_rdata1, rf_rdata2, mem_ready,
      output busy, done, err_code, rf_raddr1, rf_raddr2,
             mem_write, mem_addr, mem_wdata, mem_be
   );

   modport master (
      output start, instruction, rf_rdata1, rf_rdata2, mem_ready,
      input  busy, done, err_code, rf_raddr1, rf_raddr2,
             mem_write, mem_addr, mem_wdata, mem_be
   );
endinterface

// File: rtl/store_operation.sv
// Multi-cycle MIPS sw/sh/sb executor: 4 cycles start-to-done, +1 per mem_ready wait cycle.
// Write request held stable until mem_ready or MEM_TIMEOUT; new starts ignored while busy.
module store_operation #(
   parameter int MEM_TIMEOUT = 16
) (
   input  logic             clk,
   input  logic             reset,
   store_operation_if.slave bus
);

   localparam int               CNT_W    = $clog2(MEM_TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);
   localparam logic [5:0]       OP_SW    = 6'h2B;
   localparam logic [5:0]       OP_SH    = 6'h29;
   localparam logic [5:0]       OP_SB    = 6'h28;

   typedef enum logic [2:0] {
      S_IDLE,
      S_DECODE,
      S_ADDR,
      S_MEM,
      S_DONE
   } state_t;

   state_t           state_q, state_d;
   logic [31:0]      instr_q, instr_d;
   logic [31:0]      base_q, base_d;
   logic [31:0]      data_q, data_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [1:0]       err_d;
   logic             write_d;
   logic [31:0]      addr_d, wdata_d;
   logic [3:0]       be_d;

   logic [5:0]       opcode;
   logic [15:0]      imm;
   logic [31:0]      eff_addr;
   logic [31:0]      lane_wdata;
   logic [3:0]       lane_be;
   logic             legal, aligned;

   assign opcode        = instr_q[31:26];
   assign imm           = instr_q[15:0];
   assign bus.rf_raddr1 = instr_q[25:21];
   assign bus.rf_raddr2 = instr_q[20:16];
   assign eff_addr      = base_q + {{16{imm[15]}}, imm};

   // Lane placement: narrow data is replicated so any byte enable picks the right bytes.
   always_comb begin
      legal      = 1'b0;
      aligned    = 1'b0;
      lane_wdata = data_q;
      lane_be    = 4'b0000;
      case (opcode)
         OP_SW: begin
            legal      = 1'b1;
            aligned    = (eff_addr[1:0] == 2'b00);
            lane_wdata = data_q;
            lane_be    = 4'b1111;
         end
         OP_SH: begin
            legal      = 1'b1;
            aligned    = ~eff_addr[0];
            lane_wdata = {2{data_q[15:0]}};
            lane_be    = eff_addr[1] ? 4'b1100 : 4'b0011;
         end
         OP_SB: begin
            legal      = 1'b1;
            aligned    = 1'b1;
            lane_wdata = {4{data_q[7:0]}};
            lane_be    = 4'b0001 << eff_addr[1:0];
         end
         default: ;
      endcase
   end

   always_comb begin
      state_d = state_q;
      instr_d = instr_q;
      base_d  = base_q;
      data_d  = data_q;
      cnt_d   = cnt_q;
      err_d   = bus.err_code;
      write_d = bus.mem_write;
      addr_d  = bus.mem_addr;
      wdata_d = bus.mem_wdata;
      be_d    = bus.mem_be;
      case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               instr_d = bus.instruction;
               state_d = S_DECODE;
            end
         end
         S_DECODE: begin
            if (!legal) begin
               err_d   = 2'b01;
               state_d = S_DONE;
            end else begin
               base_d  = bus.rf_rdata1;
               data_d  = bus.rf_rdata2;
               state_d = S_ADDR;
            end
         end
         S_ADDR: begin
            if (!aligned) begin
               err_d   = 2'b10;
               state_d = S_DONE;
            end else begin
               addr_d  = eff_addr;
               wdata_d = lane_wdata;
               be_d    = lane_be;
               write_d = 1'b1;
               cnt_d   = '0;
               state_d = S_MEM;
            end
         end
         S_MEM: begin
            // A ready arriving on the last allowed cycle still counts as success.
            if (bus.mem_ready) begin
               write_d = 1'b0;
               err_d   = 2'b00;
               state_d = S_DONE;
            end else if (cnt_q == CNT_LAST) begin
               write_d = 1'b0;
               err_d   = 2'b11;
               state_d = S_DONE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= S_IDLE;
         instr_q       <= '0;
         base_q        <= '0;
         data_q        <= '0;
         cnt_q         <= '0;
         bus.busy      <= 1'b0;
         bus.done      <= 1'b0;
         bus.err_code  <= 2'b00;
         bus.mem_write <= 1'b0;
         bus.mem_addr  <= '0;
         bus.mem_wdata <= '0;
         bus.mem_be    <= '0;
      end else begin
         state_q       <= state_d;
         instr_q       <= instr_d;
         base_q        <= base_d;
         data_q        <= data_d;
         cnt_q         <= cnt_d;
         bus.busy      <= (state_d != S_IDLE);
         bus.done      <= (state_d == S_DONE);
         bus.err_code  <= err_d;
         bus.mem_write <= write_d;
         bus.mem_addr  <= addr_d;
         bus.mem_wdata <= wdata_d;
         bus.mem_be    <= be_d;
      end
   end

endmodule

// File: tb/tb_store_operation.sv
// Scoreboard bench for store_operation: expected writes/completions queued at stimulus time,
// popped and compared when the DUT handshakes with memory or pulses done.
module tb_store_operation;
   localparam int TO = 8;

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  be;
   } wr_t;

   typedef struct packed {
      logic [1:0] err;
      int         lat;
      int         wrs;
   } dn_t;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   store_operation_if bus();
   store_operation #(.MEM_TIMEOUT(TO)) dut (.clk(clk), .reset(reset), .bus(bus));

   logic [31:0] regs [32];
   assign bus.rf_rdata1 = regs[bus.rf_raddr1];
   assign bus.rf_rdata2 = regs[bus.rf_raddr2];

   wr_t exp_wr_q[$];
   dn_t exp_dn_q[$];
   wr_t ew;
   dn_t ed;
   int total = 0, bad = 0;
   int cyc = 0, st_cyc = 0, wr_hi = 0, ready_delay = 0, wcnt = 0;
   logic        prev_wr = 1'b0;
   logic [31:0] prev_addr = '0, prev_wdata = '0;
   logic [3:0]  prev_be = '0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Memory model: ready rises after ready_delay wait cycles of a pending write.
   always @(posedge clk) begin
      #1;
      if (bus.mem_write) begin
         bus.mem_ready = (wcnt >= ready_delay);
         wcnt++;
      end else begin
         bus.mem_ready = 1'b0;
         wcnt = 0;
      end
   end

   always @(negedge clk) begin
      if (reset) begin
         prev_wr = 1'b0;
      end else begin
         if (bus.start && !bus.busy) begin
            st_cyc = cyc;
            wr_hi  = 0;
         end
         if (bus.mem_write) begin
            wr_hi++;
            if (prev_wr) begin
               chk("stable_addr", bus.mem_addr, prev_addr);
               chk("stable_wdata", bus.mem_wdata, prev_wdata);
               chk("stable_be", 32'(bus.mem_be), 32'(prev_be));
            end
            if (bus.mem_ready) begin
               if (exp_wr_q.size() == 0) begin
                  chk("unexpected_write", 32'd1, 32'd0);
               end else begin
                  ew = exp_wr_q.pop_front();
                  chk("wr_addr", bus.mem_addr, ew.addr);
                  chk("wr_wdata", bus.mem_wdata, ew.wdata);
                  chk("wr_be", 32'(bus.mem_be), 32'(ew.be));
               end
            end
         end
         if (bus.done) begin
            if (exp_dn_q.size() == 0) begin
               chk("unexpected_done", 32'd1, 32'd0);
            end else begin
               ed = exp_dn_q.pop_front();
               chk("done_err", 32'(bus.err_code), 32'(ed.err));
               chk("done_latency", 32'(cyc - st_cyc), 32'(ed.lat));
               chk("write_cycles", 32'(wr_hi), 32'(ed.wrs));
               chk("busy_at_done", 32'(bus.busy), 32'd1);
            end
         end
         prev_wr    = bus.mem_write;
         prev_addr  = bus.mem_addr;
         prev_wdata = bus.mem_wdata;
         prev_be    = bus.mem_be;
      end
   end

   task automatic wait_idle(input int budget);
      for (int i = 0; i < budget && exp_dn_q.size() != 0; i++) @(posedge clk);
      if (exp_dn_q.size() != 0) begin
         chk("done_wait_budget", 32'(exp_dn_q.size()), 32'd0);
         exp_dn_q.delete();
         exp_wr_q.delete();
      end
      repeat (6) @(posedge clk);
   endtask

   task automatic pulse_start(input logic [31:0] instr);
      @(posedge clk);
      #1 bus.start = 1'b1;
      bus.instruction = instr;
      @(posedge clk);
      #1 bus.start = 1'b0;
   endtask

   // extra_at > 0 pulses an illegal start that many cycles into the operation.
   task automatic do_store(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                           input logic [15:0] imm, input logic [31:0] base,
                           input logic [31:0] data, input int delay, input int extra_at);
      logic [31:0] a;
      wr_t w;
      dn_t d;
      logic ok, leg;
      a = base + {{16{imm[15]}}, imm};
      regs[rs] = base;
      regs[rt] = data;
      ready_delay = delay;
      leg = 1'b1;
      ok = 1'b1;
      w.addr = a;
      w.wdata = data;
      w.be = 4'b1111;
      case (op)
         6'h2B: ok = (a[1:0] == 2'b00);
         6'h29: begin
            ok = ~a[0];
            w.wdata = {2{data[15:0]}};
            w.be = a[1] ? 4'b1100 : 4'b0011;
         end
         6'h28: begin
            w.wdata = {4{data[7:0]}};
            w.be = 4'b0001 << a[1:0];
         end
         default: leg = 1'b0;
      endcase
      if (!leg) begin
         d.err = 2'b01; d.lat = 2; d.wrs = 0;
      end else if (!ok) begin
         d.err = 2'b10; d.lat = 3; d.wrs = 0;
      end else if (delay < TO) begin
         d.err = 2'b00; d.lat = 4 + delay; d.wrs = 1 + delay;
         exp_wr_q.push_back(w);
      end else begin
         d.err = 2'b11; d.lat = 3 + TO; d.wrs = TO;
      end
      exp_dn_q.push_back(d);
      pulse_start({op, rs, rt, imm});
      if (extra_at > 0) begin
         repeat (extra_at) @(posedge clk);
         #1 bus.start = 1'b1;
         bus.instruction = 32'h8C00_0000;
         @(posedge clk);
         #1 bus.start = 1'b0;
      end
      wait_idle(200);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: got hang expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      for (int i = 0; i < 32; i++) regs[i] = 32'h0;
      bus.start = 1'b0;
      bus.instruction = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", 32'(bus.busy), 32'd0);
      chk("rst_done", 32'(bus.done), 32'd0);
      chk("rst_err", 32'(bus.err_code), 32'd0);
      chk("rst_mem_write", 32'(bus.mem_write), 32'd0);
      chk("rst_mem_addr", bus.mem_addr, 32'd0);
      chk("rst_mem_wdata", bus.mem_wdata, 32'd0);
      chk("rst_mem_be", 32'(bus.mem_be), 32'd0);
      chk("rst_raddr", 32'({bus.rf_raddr1, bus.rf_raddr2}), 32'd0);
      @(negedge clk) reset = 1'b0;

      do_store(6'h2B, 5'd1, 5'd2, 16'h0004, 32'h0000_1000, 32'hDEAD_BEEF, 0, 0);
      do_store(6'h28, 5'd3, 5'd4, 16'h0003, 32'h0000_1000, 32'h1234_56A5, 0, 0);
      do_store(6'h29, 5'd5, 5'd6, 16'h0002, 32'h0000_1000, 32'h0000_BEEF, 0, 0);
      do_store(6'h29, 5'd5, 5'd6, 16'h0000, 32'h0000_2000, 32'hCAFE_1234, 0, 0);
      do_store(6'h2B, 5'd7, 5'd8, 16'hFFFC, 32'h0000_1000, 32'h0BAD_F00D, 0, 0);
      do_store(6'h2B, 5'd9, 5'd10, 16'h0008, 32'hFFFF_FFFC, 32'h5555_AAAA, 0, 0);
      for (int k = 0; k < 4; k++)
         do_store(6'h28, 5'd11, 5'd12, 16'(k), 32'h0000_4000, 32'h0000_00C3 + 32'(k), 0, 0);
      do_store(6'h2B, 5'd1, 5'd2, 16'h0002, 32'h0000_1000, 32'h1111_2222, 0, 0);
      do_store(6'h29, 5'd1, 5'd2, 16'h0001, 32'h0000_1000, 32'h3333_4444, 0, 0);
      do_store(6'h23, 5'd1, 5'd2, 16'h0004, 32'h0000_1000, 32'h5555_6666, 0, 0);
      do_store(6'h2B, 5'd13, 5'd14, 16'h0010, 32'h0000_8000, 32'h7777_8888, 3, 0);
      do_store(6'h2B, 5'd13, 5'd14, 16'h0014, 32'h0000_8000, 32'h9999_AAAA, TO - 1, 0);
      do_store(6'h2B, 5'd13, 5'd14, 16'h0018, 32'h0000_8000, 32'hBBBB_CCCC, 1000, 0);
      do_store(6'h29, 5'd15, 5'd16, 16'h0006, 32'h0000_9000, 32'hDDDD_EEEE, 2, 2);
      do_store(6'h29, 5'd15, 5'd16, 16'h0006, 32'h0000_9000, 32'hDDDD_EEEE, 2, 5);

      // Reset while waiting on memory: write drops at once and no completion follows.
      regs[17] = 32'h0000_A000;
      regs[18] = 32'h1357_9BDF;
      ready_delay = 1000;
      pulse_start({6'h2B, 5'd17, 5'd18, 16'h0000});
      for (int i = 0; i < 20 && !bus.mem_write; i++) @(posedge clk);
      chk("mem_write_before_reset", 32'(bus.mem_write), 32'd1);
      repeat (3) @(posedge clk);
      #3 reset = 1'b1;
      #1;
      chk("reset_mem_write", 32'(bus.mem_write), 32'd0);
      chk("reset_busy", 32'(bus.busy), 32'd0);
      chk("reset_done", 32'(bus.done), 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk) reset = 1'b0;
      repeat (4) @(posedge clk);
      do_store(6'h2B, 5'd17, 5'd18, 16'h0008, 32'h0000_A000, 32'h2468_ACE0, 1, 0);

      chk("leftover_writes", 32'(exp_wr_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
